// File: rtl/seq_monitor_pkg.sv
// Shared types and constants for the sequence monitor: FSM state encoding,
// sequence width and the wrap-around successor helper.
package seq_monitor_pkg;

  localparam int SEQ_W = 3;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] v);
    return v + {{(SEQ_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding with a
// clear leaves the count at one so that the event is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // Count register: clear has priority over saturation, increment survives it
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= {W{1'b0}};
    end else if (clr) begin
      value_q <= inc ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_q <= value_q;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/seq_monitor.sv
// Monitors a 3-bit wrap-around counter stream, locks after LOCK_CNT legal steps
// and reports wraps/errors. Define SEQ_MONITOR_STALL_EN to treat repeats as holds.
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEQ_W-1:0]  count_in,
  input  logic              clear_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [STAT_W-1:0] lap_count,
  output logic [STAT_W-1:0] err_count
);

  state_e           state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [SEQ_W-1:0] prev_q;
  logic             locked_q, wrap_q, err_q, sticky_q;
  logic             legal_s, hold_s, wrap_s, err_s;

  // Step classification and next-state decision
  always_comb begin
    legal_s = (count_in == seq_next(prev_q));
`ifdef SEQ_MONITOR_STALL_EN
    hold_s  = (count_in == prev_q);
`else
    hold_s  = 1'b0;
`endif
    state_d = state_q;
    good_d  = good_q;
    wrap_s  = 1'b0;
    err_s   = 1'b0;
    case (state_q)
      INIT: begin
        state_d = LOCKING;
        good_d  = 4'd0;
      end
      LOCKING: begin
        if (hold_s) begin
          state_d = LOCKING;
        end else if (legal_s) begin
          good_d = good_q + 4'd1;
          if (good_d == 4'(LOCK_CNT)) begin
            state_d = LOCKED;
          end else begin
            state_d = LOCKING;
          end
        end else begin
          good_d = 4'd0;
        end
      end
      LOCKED: begin
        if (hold_s) begin
          state_d = LOCKED;
        end else if (legal_s) begin
          // a legal step out of 7 can only land on 0
          wrap_s = (prev_q == 3'd7);
        end else begin
          err_s   = 1'b1;
          good_d  = 4'd0;
          state_d = LOCKING;
        end
      end
      default: begin
        state_d = INIT;
        good_d  = 4'd0;
      end
    endcase
  end

  // FSM state plus registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      good_q   <= 4'd0;
      prev_q   <= {SEQ_W{1'b0}};
      locked_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      prev_q   <= count_in;
      locked_q <= (state_d == LOCKED);
      wrap_q   <= wrap_s;
      err_q    <= err_s;
      if (err_s) begin
        sticky_q <= 1'b1;
      end else if (clear_err) begin
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_q;
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_lap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_s),
    .clr   (1'b0),
    .value (lap_count)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_s),
    .clr   (clear_err),
    .value (err_count)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor compares them one cycle later.
module tb_seq_monitor;

  localparam int LOCK_CNT = 4;
  localparam int STAT_W   = 8;
  localparam int SAT      = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        count_in = 3'd0;
  logic              clear_err = 1'b0;
  logic              locked, wrap_pulse, err_pulse, err_sticky;
  logic [STAT_W-1:0] lap_count, err_count;

  seq_monitor #(.LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .clear_err  (clear_err),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .lap_count  (lap_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              lk;
    logic              wr;
    logic              er;
    logic              st;
    logic [STAT_W-1:0] lap;
    logic [STAT_W-1:0] ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_g;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: "fresh" means the first sample after reset is only captured
  bit fresh = 1'b1;
  bit is_locked = 1'b0;
  int streak = 0;
  int last = 0;
  int laps = 0;
  int errs = 0;
  bit sticky = 1'b0;
`ifdef SEQ_MONITOR_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  int cur = 0;

  task automatic drive(input int c, input bit clr, input bit r);
    bit   wrap, err;
    exp_t e;
    @(negedge clk);
    count_in  = 3'(c);
    clear_err = clr;
    rst       = r;
    wrap = 1'b0;
    err  = 1'b0;
    if (r) begin
      fresh = 1'b1; is_locked = 1'b0; streak = 0; last = 0;
      laps = 0; errs = 0; sticky = 1'b0;
    end else begin
      if (fresh) begin
        fresh = 1'b0;
        streak = 0;
      end else if (STALL && c == last) begin
        // repeat treated as a pause
      end else if (c == (last + 1) % 8) begin
        if (is_locked) begin
          wrap = (last == 7);
        end else begin
          streak++;
          if (streak == LOCK_CNT) is_locked = 1'b1;
        end
      end else begin
        if (is_locked) err = 1'b1;
        is_locked = 1'b0;
        streak = 0;
      end
      last = c;
      if (wrap && laps < SAT) laps++;
      if (err) begin
        sticky = 1'b1;
        errs = clr ? 1 : ((errs < SAT) ? errs + 1 : errs);
      end else if (clr) begin
        sticky = 1'b0;
        errs = 0;
      end
    end
    e.lk  = is_locked;
    e.wr  = wrap;
    e.er  = err;
    e.st  = sticky;
    e.lap = STAT_W'(laps);
    e.ec  = STAT_W'(errs);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive(cur, 1'b0, 1'b0);
      cur = (cur + 1) % 8;
    end
  endtask

  // Monitor: compare every cycle's outputs against the oldest prediction
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {locked, wrap_pulse, err_pulse, err_sticky, lap_count, err_count};
      checks++;
      if (mon_g !== mon_e) begin
        failures++;
        $display("FAIL outputs t=%0t got lk=%b wr=%b er=%b st=%b lap=%0d ec=%0d expected lk=%b wr=%b er=%b st=%b lap=%0d ec=%0d",
                 $time, mon_g.lk, mon_g.wr, mon_g.er, mon_g.st, mon_g.lap, mon_g.ec,
                 mon_e.lk, mon_e.wr, mon_e.er, mon_e.st, mon_e.lap, mon_e.ec);
      end
    end
  end

  initial begin
    int c;
    bit r, clr;
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1);
    // lock, then two wraps
    cur = 0;
    step(20);
    // 3 then 5 while locked, then relock
    drive(3, 1'b0, 1'b0);
    drive(5, 1'b0, 1'b0);
    cur = 6;
    step(10);
    // hold at 4 for three cycles
    while (cur != 4) step(1);
    drive(4, 1'b0, 1'b0);
    drive(4, 1'b0, 1'b0);
    drive(4, 1'b0, 1'b0);
    cur = 5;
    step(8);
    // clear coinciding with an illegal step, then clear alone
    step(6);
    drive((cur + 3) % 8, 1'b1, 1'b0);
    cur = (cur + 4) % 8;
    step(6);
    drive(cur, 1'b1, 1'b0);
    cur = (cur + 1) % 8;
    step(3);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) < 85) c = cur;
      else c = $urandom_range(0, 7);
      drive(c, clr, r);
      cur = (c + 1) % 8;
    end
    // lap counter saturation
    drive(0, 1'b0, 1'b1);
    cur = 0;
    step(8 * 258 + 4);
    // reset mid-run, then relock from scratch
    drive(cur, 1'b0, 1'b1);
    step(12);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive correct steps required to enter LOCKED (legal range 1..15).
REQ-002 SHALL have parameter STAT_W, default 8: width of the lap and error statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port count_in  input  3  sequence value produced by the upstream 3-bit wrap-around counter, sampled every cycle.
REQ-006 SHALL have port clear_err  input  1  synchronous clear of err_sticky and err_count.
REQ-007 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-008 SHALL have port wrap_pulse  output  1  one-cycle pulse on a legal 7->0 step while LOCKED.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse on an illegal step while LOCKED.
REQ-010 SHALL have port err_sticky  output  1  set by any err_pulse; held until clear_err or rst.
REQ-011 SHALL have port lap_count  output  STAT_W  number of wraps seen while LOCKED, saturating.
REQ-012 SHALL have port err_count  output  STAT_W  number of errors, saturating.

Function
REQ-013 SHALL register count_in into prev each cycle; a step is legal when count_in == (prev+1) mod 8, using 3-bit wrap arithmetic.
REQ-014 SHALL implement FSM states: INIT, LOCKING, LOCKED.
REQ-015 INIT: first cycle after reset; capture prev, clear good_cnt, go to LOCKING; no step is judged in this cycle.
REQ-016 LOCKING: legal step increments good_cnt; illegal step clears good_cnt; on the legal step that makes good_cnt == LOCK_CNT, go to LOCKED.
REQ-017 LOCKED: legal step stays LOCKED; illegal step asserts err_pulse, clears good_cnt, goes to LOCKING.
REQ-018 All outputs SHALL be registered; they reflect the step (prev -> count_in) sampled on the previous edge (1-cycle latency).
REQ-019 wrap_pulse SHALL assert only for a legal step with prev == 7 and count_in == 0 while in LOCKED; lap_count increments on the same edge.
REQ-020 lap_count and err_count SHALL saturate at all-ones and never wrap.
REQ-021 clear_err with a simultaneous error SHALL give err_sticky=1 and err_count=1 (the error wins over the clear).
REQ-022 Wraps and errors in LOCKING SHALL NOT pulse or count.

Reset
REQ-023 rst SHALL force state=INIT, good_cnt=0, prev=0, locked=0, wrap_pulse=0, err_pulse=0, err_sticky=0, lap_count=0, err_count=0.
REQ-024 rst asserted mid-sequence SHALL discard lock status; relock requires LOCK_CNT fresh legal steps after INIT.

Configuration
REQ-025 Macro SEQ_MONITOR_STALL_EN SHALL select stall tolerance.
REQ-026 With SEQ_MONITOR_STALL_EN defined, count_in == prev SHALL be a hold: no error, good_cnt unchanged, state unchanged.
REQ-027 Without it, count_in == prev SHALL be an illegal step.

Structure
REQ-028 Package seq_monitor_pkg SHALL hold the state enum (INIT, LOCKING, LOCKED) and the constant SEQ_W=3.
REQ-029 Saturating counter sub-module sat_counter (parameter W; inputs inc and clr) SHALL be instantiated twice, for lap_count and err_count.

Verification
REQ-030 Reset, then drive 0,1,...,7,0,1,... -> locked=1 on the cycle after the 4th legal step; wrap_pulse once per 7->0 step; lap_count=2 after two wraps.
REQ-031 While LOCKED, drive 3 then 5 -> err_pulse=1 for one cycle, err_sticky=1, err_count=1, locked=0; relock after 4 legal steps.
REQ-032 Hold count_in at 4 for 3 cycles while LOCKED -> macro defined: no error, locked stays 1; macro undefined: err_pulse on the first repeat.
REQ-033 Assert clear_err in the same cycle as an illegal step -> err_sticky=1, err_count=1; a later clear_err alone -> both return to 0.
REQ-034 Preload 255 wraps (STAT_W=8) -> lap_count holds 255 on the next wrap; assert rst mid-run -> all outputs 0 on the next edge, locked=0.
